// File: rtl/jtag_uart_tx_bridge_pkg.sv
// rtl/jtag_uart_tx_bridge_pkg.sv - register offsets, WSPACE field bounds and FSM state encoding
package jtag_uart_tx_bridge_pkg;

  localparam logic UART_DATA = 1'b0;
  localparam logic UART_CTRL = 1'b1;

  localparam int WSPACE_HI = 31;
  localparam int WSPACE_LO = 16;
  localparam int WSPACE_W  = WSPACE_HI - WSPACE_LO + 1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_CTRL = 3'd1,
    ST_CHK     = 3'd2,
    ST_WR_DATA = 3'd3,
    ST_BACKOFF = 3'd4
  } state_t;

endpackage

// File: rtl/jtag_uart_tx_bridge_if.sv
// rtl/jtag_uart_tx_bridge_if.sv - Avalon-MM link from the bridge master to the JTAG UART slave
interface jtag_uart_tx_bridge_if;

  logic        address;
  logic        chipselect;
  logic        read_n;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        waitrequest;

  modport master (
    output address, chipselect, read_n, write_n, writedata,
    input  readdata, waitrequest
  );

  modport slave (
    input  address, chipselect, read_n, write_n, writedata,
    output readdata, waitrequest
  );

endinterface

// File: rtl/jtag_uart_tx_bridge_sync_fifo_byte.sv
// rtl/jtag_uart_tx_bridge_sync_fifo_byte.sv - byte FIFO with wrap-bit pointers and head/next peek
module sync_fifo_byte #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          push,
  input  logic          pop,
  input  logic [7:0]    din,
  output logic [7:0]    dout,
  output logic [7:0]    dout_next,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  logic [7:0]    mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [AW-1:0] rd_next_idx;
  logic          do_push;
  logic          do_pop;

  assign empty       = (wr_ptr == rd_ptr);
  assign full        = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count       = wr_ptr - rd_ptr;
  assign do_pop      = pop & ~empty;
  // A pop frees the slot the simultaneous push lands in, so full does not block it.
  assign do_push     = push & (~full | do_pop);
  assign rd_next_idx = rd_ptr[AW-1:0] + 1'b1;
  assign dout        = mem[rd_ptr[AW-1:0]];
  assign dout_next   = mem[rd_next_idx];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/jtag_uart_tx_bridge.sv
// rtl/jtag_uart_tx_bridge.sv - console byte FIFO feeding the JTAG UART through a WSPACE-polling Avalon master
module jtag_uart_tx_bridge
  import jtag_uart_tx_bridge_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int AW       = 4,
  parameter int POLL_GAP = 64
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   wr_en,
  input  logic [7:0]             wr_data,
  output logic                   fifo_full,
  output logic                   fifo_empty,
  output logic [AW:0]            fifo_count,
  output logic [7:0]             drop_cnt,
  output logic                   busy,
  jtag_uart_tx_bridge_if.master  av
);

  localparam int            GW       = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam logic [GW-1:0] GAP_LOAD = GW'(POLL_GAP - 1);

  state_t                state_q, state_d;
  logic [WSPACE_W-1:0]   wspace_q, wspace_d;
  logic [GW-1:0]         gap_q, gap_d;
  logic                  addr_d, cs_d, rd_n_d, wr_n_d;
  logic [31:0]           wdata_d;
  logic                  wr_en_d;
  logic                  push_edge;
  logic                  pop;
  logic [7:0]            head, head_next;
  logic                  unused_rd;

  assign push_edge = wr_en & ~wr_en_d;
  assign unused_rd = ^av.readdata[WSPACE_LO-1:0];

  sync_fifo_byte #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push_edge),
    .pop       (pop),
    .din       (wr_data),
    .dout      (head),
    .dout_next (head_next),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_comb begin
    state_d  = state_q;
    wspace_d = wspace_q;
    gap_d    = gap_q;
    addr_d   = av.address;
    cs_d     = av.chipselect;
    rd_n_d   = av.read_n;
    wr_n_d   = av.write_n;
    wdata_d  = av.writedata;
    pop      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          state_d = ST_RD_CTRL;
          addr_d  = UART_CTRL;
          cs_d    = 1'b1;
          rd_n_d  = 1'b0;
        end
      end
      ST_RD_CTRL: begin
        if (!av.waitrequest) begin
          wspace_d = av.readdata[WSPACE_HI:WSPACE_LO];
          cs_d     = 1'b0;
          rd_n_d   = 1'b1;
          state_d  = ST_CHK;
        end
      end
      ST_CHK: begin
        if (wspace_q != '0) begin
          state_d = ST_WR_DATA;
          addr_d  = UART_DATA;
          cs_d    = 1'b1;
          wr_n_d  = 1'b0;
          wdata_d = {24'd0, head};
        end else begin
          gap_d   = GAP_LOAD;
          state_d = ST_BACKOFF;
        end
      end
      ST_WR_DATA: begin
        if (!av.waitrequest) begin
          pop      = 1'b1;
          wspace_d = wspace_q - 1'b1;
          // Stream the next byte while both the FIFO and the UART still have room.
          if (fifo_count > (AW+1)'(1) && wspace_q != WSPACE_W'(1)) begin
            wdata_d = {24'd0, head_next};
          end else begin
            cs_d    = 1'b0;
            wr_n_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      ST_BACKOFF: begin
        if (gap_q == '0) begin
          state_d = ST_RD_CTRL;
          addr_d  = UART_CTRL;
          cs_d    = 1'b1;
          rd_n_d  = 1'b0;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cs_d    = 1'b0;
        rd_n_d  = 1'b1;
        wr_n_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      wspace_q      <= '0;
      gap_q         <= '0;
      wr_en_d       <= 1'b0;
      drop_cnt      <= '0;
      busy          <= 1'b0;
      av.address    <= UART_DATA;
      av.chipselect <= 1'b0;
      av.read_n     <= 1'b1;
      av.write_n    <= 1'b1;
      av.writedata  <= '0;
    end else begin
      state_q       <= state_d;
      wspace_q      <= wspace_d;
      gap_q         <= gap_d;
      wr_en_d       <= wr_en;
      busy          <= (state_d != ST_IDLE);
      av.address    <= addr_d;
      av.chipselect <= cs_d;
      av.read_n     <= rd_n_d;
      av.write_n    <= wr_n_d;
      av.writedata  <= wdata_d;
      if (push_edge && fifo_full && !pop && drop_cnt != 8'hFF)
        drop_cnt <= drop_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_jtag_uart_tx_bridge.sv
// tb/tb_jtag_uart_tx_bridge.sv - scoreboard bench with an Avalon slave model for jtag_uart_tx_bridge
module tb_jtag_uart_tx_bridge;

  localparam int POLL_GAP = 64;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       fifo_full, fifo_empty, busy;
  logic [4:0] fifo_count;
  logic [7:0] drop_cnt;

  jtag_uart_tx_bridge_if av();

  jtag_uart_tx_bridge #(.DEPTH(16), .AW(4), .POLL_GAP(POLL_GAP)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .fifo_full  (fifo_full),
    .fifo_empty (fifo_empty),
    .fifo_count (fifo_count),
    .drop_cnt   (drop_cnt),
    .busy       (busy),
    .av         (av)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] q[$];
  logic [7:0]  ev[$];
  int          writes = 0, reads = 0, bus_cycles = 0;
  int          wait_cfg = 0, stall_cnt = 0, polls = 0, poll_base = 0, cyc = 0;
  logic [15:0] ws_first = 16'h0040, ws_later = 16'h0040;
  bit          gap_meas = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
    checks++;
    if (got !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp_v);
    end
  endtask

  // Slave: each access stalls wait_cfg cycles, first poll after poll_base returns ws_first.
  assign av.waitrequest = av.chipselect && (!av.read_n || !av.write_n) && (stall_cnt != 0);
  assign av.readdata    = {(polls == poll_base) ? ws_first : ws_later, 16'h0000};

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (av.chipselect && (!av.read_n || !av.write_n)) begin
      if (!av.waitrequest) begin
        stall_cnt <= wait_cfg;
        if (!av.read_n) polls <= polls + 1;
      end else begin
        stall_cnt <= stall_cnt - 1;
      end
    end else begin
      stall_cnt <= wait_cfg;
    end
  end

  initial begin : monitor
    bit          w_stalled = 0, rd_prev = 0;
    logic [31:0] held = '0, exp_w;
    int          last_rd = -1;
    forever begin
      @(negedge clk);
      if (!gap_meas) last_rd = -1;
      if (!reset_n) begin
        w_stalled = 0;
        rd_prev   = 0;
      end else begin
        if (av.chipselect) begin
          bus_cycles++;
          chk("rw_excl", {31'd0, av.read_n | av.write_n}, 32'd1);
        end
        if (av.chipselect && !av.write_n) begin
          if (av.waitrequest) begin
            if (w_stalled) chk("wdata_stable", av.writedata, held);
            held      = av.writedata;
            w_stalled = 1;
          end else begin
            exp_w = (q.size() > 0) ? q.pop_front() : 32'hDEAD_BEEF;
            chk("wdata", av.writedata, exp_w);
            writes++;
            ev.push_back(8'h57);
            w_stalled = 0;
          end
        end else begin
          w_stalled = 0;
        end
        if (av.chipselect && !av.read_n) begin
          if (!rd_prev) begin
            if (gap_meas && last_rd >= 0) chk("poll_gap", cyc - last_rd, POLL_GAP + 2);
            last_rd = cyc;
          end
          if (!av.waitrequest) begin
            reads++;
            ev.push_back(8'h52);
          end
        end
        rd_prev = av.chipselect && !av.read_n;
      end
    end
  end

  task automatic do_reset();
    reset_n = 1'b0;
    wr_en   = 1'b0;
    repeat (3) @(negedge clk);
    q.delete();
    ev.delete();
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic push_byte(input logic [7:0] b, input bit expect_out);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_data = b;
    if (expect_out) q.push_back({24'd0, b});
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_drain(input int max_cyc);
    int n = 0;
    while ((q.size() != 0 || busy) && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", {31'd0, n < max_cyc}, 32'd1);
    chk("sb_empty", q.size(), 0);
  endtask

  initial begin
    int          w0, r0, b0, n;
    logic [7:0]  hello[5];
    logic [7:0]  exp_ev[6];
    hello  = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F};
    exp_ev = '{8'h52, 8'h57, 8'h57, 8'h52, 8'h57, 8'h57};

    // Reset state and single held write with latency
    do_reset();
    wait_cfg = 0; ws_first = 16'h0040; ws_later = 16'h0040; poll_base = polls;
    chk("rst_empty", fifo_empty, 1);
    chk("rst_full", fifo_full, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_drop", drop_cnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cs", av.chipselect, 0);
    chk("rst_rd_n", av.read_n, 1);
    chk("rst_wr_n", av.write_n, 1);
    chk("rst_addr", av.address, 0);
    chk("rst_wdata", av.writedata, 0);
    w0 = writes;
    @(negedge clk);
    wr_en = 1'b1; wr_data = 8'h41; q.push_back(32'h41);
    @(posedge clk);
    @(posedge clk); #1;
    chk("lat_rd_n_e1", av.read_n, 0);
    chk("lat_addr_e1", av.address, 1);
    @(posedge clk); #1;
    chk("lat_wr_n_e2", av.write_n, 1);
    @(posedge clk); #1;
    chk("lat_wr_n_e3", av.write_n, 0);
    chk("lat_addr_e3", av.address, 0);
    repeat (196) @(negedge clk);
    wr_en = 1'b0;
    wait_drain(50);
    chk("t1_writes", writes - w0, 1);
    chk("t1_drop", drop_cnt, 0);

    // Burst ordering under 10-cycle stalls
    do_reset();
    wait_cfg = 10; poll_base = polls; w0 = writes;
    for (int i = 0; i < 5; i++) push_byte(hello[i], 1);
    wait_drain(1000);
    chk("t2_writes", writes - w0, 5);

    // Overflow with WSPACE stuck at zero
    do_reset();
    wait_cfg = 0; ws_first = 16'h0000; ws_later = 16'h0000; poll_base = polls;
    gap_meas = 1; w0 = writes; r0 = reads;
    for (int i = 0; i < 20; i++) begin
      push_byte(8'h30 + 8'(i), 0);
      if (i == 15) begin
        chk("t3_full16", fifo_full, 1);
        chk("t3_count16", fifo_count, 16);
      end
    end
    chk("t3_drop", drop_cnt, 4);
    chk("t3_count20", fifo_count, 16);
    repeat (200) @(negedge clk);
    gap_meas = 0;
    chk("t3_no_write", writes - w0, 0);
    chk("t3_polls", {31'd0, (reads - r0) >= 3}, 32'd1);

    // WSPACE limit splits the queue across two polls
    do_reset();
    wait_cfg = 12; ws_first = 16'h0002; ws_later = 16'h0040; poll_base = polls;
    for (int i = 0; i < 4; i++) push_byte(8'h31 + 8'(i), 1);
    wait_drain(1000);
    chk("t4_ev_n", ev.size(), 6);
    for (int i = 0; i < 6; i++)
      chk($sformatf("t4_ev%0d", i), (i < ev.size()) ? {24'd0, ev[i]} : 32'd0, {24'd0, exp_ev[i]});

    // Reset during a stalled write
    do_reset();
    wait_cfg = 60; ws_first = 16'h0040; ws_later = 16'h0040; poll_base = polls;
    push_byte(8'h5A, 0);
    n = 0;
    while (av.write_n && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("t5_reach_wr", av.write_n, 0);
    chk("t5_stalled", av.waitrequest, 1);
    reset_n = 1'b0;
    #1;
    chk("t5_wr_n", av.write_n, 1);
    chk("t5_cs", av.chipselect, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    b0 = bus_cycles;
    repeat (100) @(negedge clk);
    chk("t5_empty", fifo_empty, 1);
    chk("t5_quiet", bus_cycles - b0, 0);
    chk("t5_busy", busy, 0);

    // Push accepted while full because a pop lands on the same edge
    do_reset();
    wait_cfg = 40; poll_base = polls; w0 = writes;
    for (int i = 0; i < 16; i++) push_byte(8'h61 + 8'(i), 1);
    chk("t6_full", fifo_full, 1);
    n = 0;
    while (!(av.chipselect && !av.write_n && !av.waitrequest) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("t6_reach", {31'd0, n < 300}, 32'd1);
    wr_en = 1'b1; wr_data = 8'h71; q.push_back(32'h71);
    wait_cfg = 0;
    @(posedge clk); #1;
    chk("t6_count", fifo_count, 16);
    chk("t6_full_after", fifo_full, 1);
    chk("t6_drop", drop_cnt, 0);
    @(negedge clk);
    wr_en = 1'b0;
    wait_drain(1000);
    chk("t6_writes", writes - w0, 17);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/jtag_uart_tx_bridge.md
Name: jtag_uart_tx_bridge

Overview:
- Sits between the CPU bus write decode for the console address (Art_base) and the Avalon JTAG UART slave.
- Replaces the single-pulse direct write path with a TX byte FIFO plus an Avalon master FSM.
- The FSM polls the UART control register's WSPACE field before each data write, so characters are never lost to a full JTAG FIFO or an ignored waitrequest.
- Runs in the 50 MHz domain; the CPU's slow-clock bus strobes arrive as long levels.

Parameters:
- DEPTH, 16: TX FIFO entries; power of 2, at least 2.
- AW, 4: log2(DEPTH).
- POLL_GAP, 64: idle cycles between WSPACE polls when WSPACE=0.

Ports:
- clk  in  1  50 MHz clock (CLOCK_50)
- reset_n  in  1  asynchronous active-low reset (KEY0)
- wr_en  in  1  bus write strobe qualified by Art_selected; a level that may be held many cycles
- wr_data  in  8  character byte (bus_write_data[7:0])
- fifo_full  out  1  FIFO holds DEPTH bytes
- fifo_empty  out  1  FIFO holds 0 bytes
- fifo_count  out  AW+1  current occupancy
- drop_cnt  out  8  count of bytes dropped because the FIFO was full; saturates
- busy  out  1  FSM not in IDLE
- av_address  out  1  0 = DATA register, 1 = CONTROL register
- av_chipselect  out  1  asserted during a transfer
- av_read_n  out  1  active-low read strobe
- av_write_n  out  1  active-low write strobe
- av_writedata  out  32  {24'd0, byte}
- av_readdata  in  32  slave read data
- av_waitrequest  in  1  slave stall

Behaviour:
- Reset (asynchronous, reset_n=0):
  - State returns to IDLE; FIFO pointers cleared; the captured WSPACE value and the wr_en delay register cleared.
  - av_chipselect=0, av_read_n=1, av_write_n=1, av_address=0, av_writedata=0.
  - fifo_empty=1, fifo_full=0, fifo_count=0, drop_cnt=0, busy=0.
  - Reset asserted mid-transfer aborts the transfer immediately and discards FIFO contents.
- All outputs are registered.
- Push rule:
  - One push per rising edge of wr_en (wr_en=1 and the previous-cycle wr_en=0). A held wr_en never pushes twice.
  - A push is accepted if the FIFO is not full, or if a pop happens in the same cycle.
  - Otherwise the byte is dropped and drop_cnt increments, saturating at 255.
- Pointers are AW+1 bits wide and wrap modulo 2*DEPTH.
  - full when the MSBs differ and the low AW bits are equal.
  - empty when the pointers are equal.
- FSM states: IDLE, RD_CTRL, CHK, WR_DATA, BACKOFF.
  - IDLE: if !empty, go to RD_CTRL and drive av_address=1, av_chipselect=1, av_read_n=0.
  - RD_CTRL: hold the strobes while av_waitrequest=1. On the first cycle with waitrequest=0, capture av_readdata[31:16] as wspace, deassert the strobes, go to CHK.
  - CHK: if wspace≠0, go to WR_DATA and drive av_address=0, av_write_n=0, av_chipselect=1, av_writedata={24'd0, FIFO head}. Otherwise load the gap counter with POLL_GAP-1 and go to BACKOFF.
  - WR_DATA: hold while waitrequest=1, with av_writedata stable. On waitrequest=0, pop the head and decrement wspace.
    - If the FIFO still holds data (count>1 before the pop) and wspace-1≠0, stay in WR_DATA with the next byte (back-to-back writes).
    - Otherwise deassert the strobes and go to IDLE.
  - BACKOFF: decrement the counter; at 0 go to RD_CTRL.
- Read and write strobes are never asserted in the same cycle.
- Latency with zero wait states, push edge sampled at edge 0:
  - av_read_n low after edge 1.
  - wspace captured at edge 2.
  - av_write_n low after edge 3.
  - Pop at edge 4.
- Byte order is preserved strictly FIFO.

Decomposition:
- Shared package (the header include) holds:
  - Register offsets UART_DATA=1'b0 and UART_CTRL=1'b1.
  - WSPACE field bounds [31:16].
  - The 3-bit state encoding localparams: IDLE=0, RD_CTRL=1, CHK=2, WR_DATA=3, BACKOFF=4.
- One sub-module, sync_fifo_byte: parameterised DEPTH/AW, with push, pop, dout (head, combinational), full, empty and count.
- The FSM, edge detect and drop counter stay in jtag_uart_tx_bridge.

Test Plan:
- Reset then a single write:
  - Stimulus: wr_en held 200 cycles with 0x41; slave with no wait states, readdata[31:16]=0x0040.
  - Required: exactly one write of 0x00000041 to address 0, with av_write_n low after edge 3; drop_cnt=0.
- Burst ordering:
  - Stimulus: push 'H','e','l','l','o' while av_waitrequest is held at 1 for 10 cycles on each access.
  - Required: five writes in order 0x48, 0x65, 0x6C, 0x6C, 0x6F; av_writedata stable during each stall.
- Overflow:
  - Stimulus: WSPACE=0 forever, 20 pushes.
  - Required: fifo_full=1 and fifo_count=16 after the 16th push; drop_cnt=4; no av_write_n assertion; reads spaced POLL_GAP+2 cycles apart.
- WSPACE limit:
  - Stimulus: 4 bytes queued, first poll returns WSPACE=2, later polls return 0x40.
  - Required: 2 back-to-back writes, a fresh RD_CTRL read, then the remaining 2 writes.
- Reset mid-write:
  - Stimulus: assert reset_n=0 while av_write_n=0 and waitrequest=1.
  - Required: within the same cycle av_write_n=1 and av_chipselect=0; after release fifo_empty=1 and no further bus activity.
- Push during pop when full:
  - Stimulus: FIFO full, WR_DATA completes in the same cycle as a wr_en rising edge.
  - Required: the byte is accepted, fifo_count stays 16, drop_cnt is unchanged.
